// File: rtl/arm_data_mem_responder.sv
// Data-memory responder for the pipelined ARM core: word RAM with byte lanes,
// a fixed number of wait states per access and a combinational stall request.
module arm_data_mem_responder #(
    parameter int BusWidth   = 32,
    parameter int Depth      = 64,
    parameter int WaitStates = 2
) (
    input  logic                i_CLK,
    input  logic                i_RESET,
    input  logic                i_Mem_Read,
    input  logic                i_Mem_Write,
    input  logic [BusWidth-1:0] i_Data_Addr,
    input  logic [BusWidth-1:0] i_Write_Data,
    input  logic [3:0]          i_Byte_EN,
    output logic [BusWidth-1:0] o_Read_Data,
    output logic                o_Busy,
    output logic                o_Done,
    output logic                o_Addr_Error
);

    localparam int AW = $clog2(Depth);
    localparam int LoadInt = (WaitStates > 0) ? WaitStates - 1 : 0;
    localparam logic [3:0] LoadCnt = 4'(LoadInt);

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_t;

    state_t state, state_nxt;
    logic [3:0] cnt, cnt_nxt;

    logic [BusWidth-1:0] lat_addr, lat_data;
    logic [3:0]          lat_be;
    logic                lat_wr;

    logic [BusWidth-1:0] mem [Depth];

    logic                req, start;
    logic [BusWidth-1:0] sel_addr, sel_data;
    logic [3:0]          sel_be;
    logic                sel_wr;
    logic                fault, complete, busy, wr_en;
    logic [AW-1:0]       idx;

    assign req   = i_Mem_Read | i_Mem_Write;
    assign start = (state == S_IDLE) && req && (WaitStates != 0);

    // While waiting, the latched copy of the request is authoritative.
    assign sel_addr = (state == S_WAIT) ? lat_addr : i_Data_Addr;
    assign sel_data = (state == S_WAIT) ? lat_data : i_Write_Data;
    assign sel_be   = (state == S_WAIT) ? lat_be   : i_Byte_EN;
    assign sel_wr   = (state == S_WAIT) ? lat_wr   : i_Mem_Write;

    assign idx   = sel_addr[AW+1:2];
    assign fault = (sel_addr[1:0] != 2'b00) ||
                   (sel_addr[BusWidth-1:AW+2] != '0);

    always_ff @(posedge i_CLK or posedge i_RESET) begin
        if (i_RESET) begin
            state    <= S_IDLE;
            cnt      <= 4'd0;
            lat_addr <= '0;
            lat_data <= '0;
            lat_be   <= 4'd0;
            lat_wr   <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (start) begin
                lat_addr <= i_Data_Addr;
                lat_data <= i_Write_Data;
                lat_be   <= i_Byte_EN;
                lat_wr   <= i_Mem_Write;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_WAIT;
                    cnt_nxt   = LoadCnt;
                end
            end
            S_WAIT: begin
                if (cnt == 4'd0) state_nxt = S_IDLE;
                else             cnt_nxt   = cnt - 4'd1;
            end
        endcase
    end

    // Outputs are forced low while reset is held, even with a request present.
    always_comb begin
        busy     = 1'b0;
        complete = 1'b0;
        if (!i_RESET) begin
            unique case (state)
                S_IDLE: begin
                    busy     = start;
                    complete = req && (WaitStates == 0);
                end
                S_WAIT: begin
                    busy     = (cnt != 4'd0);
                    complete = (cnt == 4'd0);
                end
            endcase
        end
    end

    assign wr_en        = complete && sel_wr && !fault;
    assign o_Busy       = busy;
    assign o_Done       = complete;
    assign o_Addr_Error = complete && fault;
    assign o_Read_Data  = (complete && !sel_wr && !fault) ? mem[idx] : '0;

    always_ff @(posedge i_CLK) begin
        if (wr_en) begin
            for (int k = 0; k < 4; k++) begin
                if (sel_be[k]) mem[idx][8*k +: 8] <= sel_data[8*k +: 8];
            end
        end
    end

endmodule

// File: tb/tb_arm_data_mem_responder.sv
// Randomized self-checking bench for arm_data_mem_responder against a
// word-array model, with one instance at 2 wait states and one at 0.
module tb_arm_data_mem_responder;

    localparam int WS = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        rd, wr;
    logic [31:0] addr, wdata;
    logic [3:0]  be;
    logic [31:0] rdata;
    logic        busy, done, err;

    logic        rd0, wr0;
    logic [31:0] addr0, wdata0;
    logic [3:0]  be0;
    logic [31:0] rdata0;
    logic        busy0, done0, err0;

    int tests = 0;
    int fails = 0;

    logic [31:0] model  [64];
    logic [31:0] model0 [64];

    always #5 clk = ~clk;

    arm_data_mem_responder #(.BusWidth(32), .Depth(64), .WaitStates(WS)) dut (
        .i_CLK(clk), .i_RESET(rst),
        .i_Mem_Read(rd), .i_Mem_Write(wr),
        .i_Data_Addr(addr), .i_Write_Data(wdata), .i_Byte_EN(be),
        .o_Read_Data(rdata), .o_Busy(busy), .o_Done(done),
        .o_Addr_Error(err)
    );

    arm_data_mem_responder #(.BusWidth(32), .Depth(64), .WaitStates(0)) dut0 (
        .i_CLK(clk), .i_RESET(rst),
        .i_Mem_Read(rd0), .i_Mem_Write(wr0),
        .i_Data_Addr(addr0), .i_Write_Data(wdata0), .i_Byte_EN(be0),
        .o_Read_Data(rdata0), .o_Busy(busy0), .o_Done(done0),
        .o_Addr_Error(err0)
    );

    function automatic bit is_fault(input logic [31:0] a);
        return (a % 4 != 0) || (a >= 32'd256);
    endfunction

    function automatic logic [31:0] lane_mask(input logic [3:0] b);
        logic [31:0] m;
        m = 32'h0;
        for (int k = 0; k < 4; k++) if (b[k]) m = m | (32'hFF << (8 * k));
        return m;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old,
                                          input logic [31:0] d,
                                          input logic [3:0] b);
        return (old & ~lane_mask(b)) | (d & lane_mask(b));
    endfunction

    // Drive one access on the wait-state instance and observe it.
    task automatic do_access(input logic r, input logic w,
                             input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] b,
                             output logic [31:0] got, output int busy_n,
                             output int done_cyc, output logic got_err);
        @(negedge clk);
        rd = r; wr = w; addr = a; wdata = d; be = b;
        busy_n = 0; done_cyc = 0; got = 32'h0; got_err = 1'b0;
        for (int c = 1; c <= WS + 4; c++) begin
            #1;
            if (busy) busy_n++;
            if (done) begin
                done_cyc = c; got = rdata; got_err = err;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        rd = 1'b0; wr = 1'b0;
    endtask

    task automatic do_access0(input logic r, input logic w,
                              input logic [31:0] a, input logic [31:0] d,
                              input logic [3:0] b,
                              output logic [31:0] got, output logic got_busy,
                              output logic got_done, output logic got_err);
        @(negedge clk);
        rd0 = r; wr0 = w; addr0 = a; wdata0 = d; be0 = b;
        #1;
        got = rdata0; got_busy = busy0; got_done = done0; got_err = err0;
    endtask

    task automatic test_reset;
        #2;
        tests++;
        if ({busy, done, err, rdata} !== 35'h0) begin
            fails++;
            $display("FAIL reset_outputs ws2: got %h want 0", {busy, done, err, rdata});
        end
        tests++;
        if ({busy0, done0, err0, rdata0} !== 35'h0) begin
            fails++;
            $display("FAIL reset_outputs ws0: got %h want 0", {busy0, done0, err0, rdata0});
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic init_rams;
        logic [31:0] g; int bn, dc; logic e, bb, dd;
        for (int i = 0; i < 64; i++) begin
            model[i] = $urandom;
            do_access(1'b0, 1'b1, 32'(i * 4), model[i], 4'hF, g, bn, dc, e);
        end
        for (int i = 0; i < 64; i++) begin
            model0[i] = $urandom;
            do_access0(1'b0, 1'b1, 32'(i * 4), model0[i], 4'hF, g, bb, dd, e);
        end
        @(negedge clk);
        rd0 = 1'b0; wr0 = 1'b0;
    endtask

    task automatic test_write_read;
        logic [31:0] g; int bn, dc; logic e;
        do_access(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, g, bn, dc, e);
        model[4] = 32'hDEADBEEF;
        tests++;
        if (bn !== WS || dc !== WS + 1) begin
            fails++;
            $display("FAIL wr_timing: busy=%0d done_cycle=%0d want %0d/%0d", bn, dc, WS, WS + 1);
        end
        do_access(1'b1, 1'b0, 32'h10, 32'h0, 4'h0, g, bn, dc, e);
        tests++;
        if (bn !== WS || dc !== WS + 1) begin
            fails++;
            $display("FAIL rd_timing: busy=%0d done_cycle=%0d want %0d/%0d", bn, dc, WS, WS + 1);
        end
        tests++;
        if (g !== 32'hDEADBEEF || e !== 1'b0) begin
            fails++;
            $display("FAIL rd_data: got %h err=%b want deadbeef err=0", g, e);
        end
    endtask

    task automatic test_byte_lanes;
        logic [31:0] g; int bn, dc; logic e;
        do_access(1'b0, 1'b1, 32'h20, 32'h11223344, 4'hF, g, bn, dc, e);
        do_access(1'b0, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, g, bn, dc, e);
        model[8] = merge(32'h11223344, 32'hAABBCCDD, 4'b0101);
        do_access(1'b1, 1'b0, 32'h20, 32'h0, 4'h0, g, bn, dc, e);
        tests++;
        if (g !== 32'h11BB33DD) begin
            fails++;
            $display("FAIL byte_lanes: got %h want 11bb33dd", g);
        end
        do_access(1'b0, 1'b1, 32'h20, 32'h55555555, 4'h0, g, bn, dc, e);
        tests++;
        if (dc !== WS + 1 || e !== 1'b0) begin
            fails++;
            $display("FAIL be_zero_done: done_cycle=%0d err=%b want %0d/0", dc, e, WS + 1);
        end
        do_access(1'b1, 1'b1 ^ 1'b1, 32'h20, 32'h0, 4'hA, g, bn, dc, e);
        tests++;
        if (g !== 32'h11BB33DD) begin
            fails++;
            $display("FAIL be_zero_nochange: got %h want 11bb33dd", g);
        end
    endtask

    task automatic test_faults;
        logic [31:0] g; int bn, dc; logic e;
        do_access(1'b1, 1'b0, 32'h102, 32'h0, 4'hF, g, bn, dc, e);
        tests++;
        if (bn !== WS || dc !== WS + 1 || e !== 1'b1 || g !== 32'h0) begin
            fails++;
            $display("FAIL fault_misaligned: busy=%0d dc=%0d err=%b data=%h want %0d/%0d/1/0",
                     bn, dc, e, g, WS, WS + 1);
        end
        do_access(1'b0, 1'b1, 32'h100, 32'hFFFFFFFF, 4'hF, g, bn, dc, e);
        tests++;
        if (bn !== WS || dc !== WS + 1 || e !== 1'b1) begin
            fails++;
            $display("FAIL fault_range: busy=%0d dc=%0d err=%b want %0d/%0d/1", bn, dc, e, WS, WS + 1);
        end
        do_access(1'b1, 1'b0, 32'h0, 32'h0, 4'hF, g, bn, dc, e);
        tests++;
        if (g !== model[0] || e !== 1'b0) begin
            fails++;
            $display("FAIL fault_no_alias: got %h err=%b want %h err=0", g, e, model[0]);
        end
        do_access(1'b1, 1'b0, 32'hFC, 32'h0, 4'hF, g, bn, dc, e);
        tests++;
        if (g !== model[63] || e !== 1'b0) begin
            fails++;
            $display("FAIL last_word: got %h err=%b want %h err=0", g, e, model[63]);
        end
    endtask

    task automatic test_both;
        logic [31:0] g; int bn, dc; logic e;
        do_access(1'b1, 1'b1, 32'h0C, 32'h12345678, 4'hF, g, bn, dc, e);
        model[3] = 32'h12345678;
        tests++;
        if (g !== 32'h0 || dc !== WS + 1) begin
            fails++;
            $display("FAIL both_as_write: data=%h dc=%0d want 0/%0d", g, dc, WS + 1);
        end
        do_access(1'b1, 1'b0, 32'h0C, 32'h0, 4'hF, g, bn, dc, e);
        tests++;
        if (g !== 32'h12345678) begin
            fails++;
            $display("FAIL both_readback: got %h want 12345678", g);
        end
    endtask

    task automatic test_latch;
        logic [31:0] g; int bn, dc; logic e;
        @(negedge clk);
        wr = 1'b1; addr = 32'h14; wdata = 32'hCAFEF00D; be = 4'hF;
        @(negedge clk);
        addr = 32'h18; wdata = 32'h0BADBEEF; be = 4'h1;
        repeat (WS) @(negedge clk);
        wr = 1'b0;
        model[5] = 32'hCAFEF00D;
        do_access(1'b1, 1'b0, 32'h14, 32'h0, 4'h0, g, bn, dc, e);
        tests++;
        if (g !== model[5]) begin
            fails++;
            $display("FAIL latch_addr: got %h want %h", g, model[5]);
        end
        do_access(1'b1, 1'b0, 32'h18, 32'h0, 4'h0, g, bn, dc, e);
        tests++;
        if (g !== model[6]) begin
            fails++;
            $display("FAIL latch_other: got %h want %h", g, model[6]);
        end
    endtask

    task automatic test_back_to_back;
        logic [5:0] bs, ds; logic [31:0] g;
        bs = 6'h0; ds = 6'h0; g = 32'h0;
        @(negedge clk);
        rd = 1'b1; addr = 32'h10;
        for (int c = 0; c < 6; c++) begin
            #1;
            bs[c] = busy; ds[c] = done;
            if (c == 2) g = rdata;
            @(negedge clk);
        end
        rd = 1'b0;
        tests++;
        if (bs !== 6'b011011 || ds !== 6'b100100) begin
            fails++;
            $display("FAIL back_to_back: busy=%b done=%b want 011011/100100", bs, ds);
        end
        tests++;
        if (g !== model[4]) begin
            fails++;
            $display("FAIL back_to_back_data: got %h want %h", g, model[4]);
        end
    endtask

    task automatic test_random;
        logic [31:0] g, a, d, exp; int bn, dc; logic e, r, w;
        logic [3:0] b; int op; bit f;
        for (int n = 0; n < 40; n++) begin
            op = $urandom_range(0, 2);
            r = (op != 1); w = (op != 0);
            case ($urandom_range(0, 5))
                0: a = 32'($urandom_range(0, 255));
                1: a = 32'h100 + 32'($urandom_range(0, 1023));
                default: a = 32'($urandom_range(0, 63)) * 4;
            endcase
            d = $urandom; b = 4'($urandom_range(0, 15));
            f = is_fault(a);
            exp = (w || f) ? 32'h0 : model[a[7:2]];
            do_access(r, w, a, d, b, g, bn, dc, e);
            if (w && !f) model[a[7:2]] = merge(model[a[7:2]], d, b);
            tests++;
            if (g !== exp || e !== f || bn !== WS || dc !== WS + 1) begin
                fails++;
                $display("FAIL random[%0d] a=%h r=%b w=%b: data=%h err=%b busy=%0d dc=%0d want %h/%b/%0d/%0d",
                         n, a, r, w, g, e, bn, dc, exp, f, WS, WS + 1);
            end
        end
    endtask

    task automatic test_reset_mid;
        logic [31:0] old, g; int bn, dc, seen; logic e;
        old = model[2];
        @(negedge clk);
        wr = 1'b1; addr = 32'h08; wdata = 32'h5A5A5A5A; be = 4'hF;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        tests++;
        if ({busy, done, err, rdata} !== 35'h0) begin
            fails++;
            $display("FAIL reset_mid_outputs: got %h want 0", {busy, done, err, rdata});
        end
        wr = 1'b0;
        #1 rst = 1'b0;
        seen = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk); #1;
            if (done || busy) seen++;
        end
        tests++;
        if (seen !== 0) begin
            fails++;
            $display("FAIL reset_mid_idle: %0d active cycles want 0", seen);
        end
        do_access(1'b1, 1'b0, 32'h08, 32'h0, 4'hF, g, bn, dc, e);
        tests++;
        if (g !== old) begin
            fails++;
            $display("FAIL reset_mid_ram: got %h want %h", g, old);
        end
    endtask

    task automatic test_ws0;
        logic [31:0] g, d, a, exp; logic bb, dd, e, w; logic [3:0] b; bit f;
        int bad_busy, bad_done, bad_data;
        bad_busy = 0; bad_done = 0; bad_data = 0;
        for (int n = 0; n < 10; n++) begin
            d = $urandom;
            do_access0(1'b0, 1'b1, 32'h04, d, 4'hF, g, bb, dd, e);
            model0[1] = d;
            if (bb) bad_busy++;
            if (!dd) bad_done++;
            do_access0(1'b1, 1'b0, 32'h04, 32'h0, 4'h0, g, bb, dd, e);
            if (bb) bad_busy++;
            if (!dd) bad_done++;
            if (g !== d) bad_data++;
        end
        tests++;
        if (bad_busy !== 0 || bad_done !== 0) begin
            fails++;
            $display("FAIL ws0_handshake: busy_cycles=%0d missing_done=%0d want 0/0", bad_busy, bad_done);
        end
        tests++;
        if (bad_data !== 0) begin
            fails++;
            $display("FAIL ws0_alternate: %0d wrong reads want 0", bad_data);
        end
        for (int n = 0; n < 30; n++) begin
            w = 1'($urandom_range(0, 1));
            a = ($urandom_range(0, 4) == 0) ? 32'($urandom_range(0, 300))
                                            : 32'($urandom_range(0, 63)) * 4;
            d = $urandom; b = 4'($urandom_range(0, 15));
            f = is_fault(a);
            exp = (w || f) ? 32'h0 : model0[a[7:2]];
            do_access0(!w, w, a, d, b, g, bb, dd, e);
            if (w && !f) model0[a[7:2]] = merge(model0[a[7:2]], d, b);
            tests++;
            if (g !== exp || e !== f || bb !== 1'b0 || dd !== 1'b1) begin
                fails++;
                $display("FAIL ws0_random[%0d] a=%h w=%b: data=%h err=%b busy=%b done=%b want %h/%b/0/1",
                         n, a, w, g, e, bb, dd, exp, f);
            end
        end
        @(negedge clk);
        rd0 = 1'b0; wr0 = 1'b0;
    endtask

    initial begin
        rd = 1'b0; wr = 1'b0; addr = 32'h0; wdata = 32'h0; be = 4'h0;
        rd0 = 1'b0; wr0 = 1'b0; addr0 = 32'h0; wdata0 = 32'h0; be0 = 4'h0;
        test_reset;
        init_rams;
        test_write_read;
        test_byte_lanes;
        test_faults;
        test_both;
        test_latch;
        test_back_to_back;
        test_random;
        test_reset_mid;
        test_ws0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/arm_data_mem_responder.md
Name: arm_data_mem_responder

Overview:
- Data-memory responder for the pipelined ARM core's data port. It sits on the far side of the Memory stage and serves the core's data address, write data and read data lines.
- Holds a word-addressed RAM with byte-lane write enables.
- Inserts a configurable number of wait states. During those cycles it drives a stall request to the hazard unit, which freezes the pipeline until the access completes.

Parameters:
- BusWidth, 32, data and address width (fixed at 32; byte lanes assume 4 bytes).
- Depth, 64, number of 32-bit words in the RAM (power of two).
- WaitStates, 2, stall cycles per access (0..15); 0 gives a single-cycle access.

Ports:
- i_CLK  in  1  clock; all state changes on its rising edge.
- i_RESET  in  1  asynchronous, active-high reset.
- i_Mem_Read  in  1  read request from the Memory stage.
- i_Mem_Write  in  1  write request from the Memory stage.
- i_Data_Addr  in  32  byte address; held stable by the core while o_Busy=1.
- i_Write_Data  in  32  store data.
- i_Byte_EN  in  4  byte-lane enables; bit k covers bits [8k+7:8k].
- o_Read_Data  out  32  load data; valid only in the completion cycle.
- o_Busy  out  1  stall request to the hazard unit; combinational.
- o_Done  out  1  high in the completion cycle of any access.
- o_Addr_Error  out  1  high in the completion cycle of a faulting access.

Behaviour:
- Reset (async, active-high):
  - state=IDLE, wait counter=0, latched request cleared.
  - All outputs 0.
  - RAM contents are not cleared.
  - A reset in mid-access aborts it: a pending write is dropped and no o_Done is produced.
- Request:
  - req = i_Mem_Read | i_Mem_Write.
  - If both are asserted, treat the access as a write and ignore the read.
- State IDLE, req=0: o_Busy=0, o_Done=0, o_Read_Data=0.
- State IDLE, req=1, WaitStates=0 (completion in the same cycle):
  - o_Busy=0, o_Done=1.
  - o_Read_Data = RAM[word index] combinationally.
  - The write commits at the next edge.
  - Remain in IDLE.
- State IDLE, req=1, WaitStates>0:
  - o_Busy=1.
  - At the edge, latch address, data, byte enables and op; load counter = WaitStates-1; go to WAIT.
- State WAIT, counter≠0: o_Busy=1; counter decrements at each edge.
- State WAIT, counter=0 (completion cycle):
  - o_Busy=0, o_Done=1.
  - o_Read_Data = RAM[latched index] for a read, 0 for a write.
  - The write commits at the edge.
  - Go to IDLE.
- Timing: an access stalls for exactly WaitStates cycles. Completion falls in cycle WaitStates+1 after the request appears, and the core samples o_Read_Data at the end of that cycle.
- Back-to-back requests: a new request is only recognised in IDLE, so a held request re-issues one cycle after completion. No completion-cycle pipelining.
- Word index = address[log2(Depth)+1:2].
- Fault conditions: address[1:0]≠0, or address ≥ 4*Depth.
- On a fault:
  - Full wait-state latency still applies.
  - Writes are dropped; reads return 0.
  - o_Addr_Error=1 together with o_Done.
- Byte enables:
  - Only enabled lanes are written.
  - i_Byte_EN=0 on a write completes normally with no RAM change.
  - Reads ignore byte enables and return the full word.
- Request changes while o_Busy=1 are ignored because the latched copy is used. The protocol requires the core to hold its inputs.

Test Plan:
1. Write then read, WaitStates=2:
   - Stimulus: write addr 0x10, data 0xDEADBEEF, BE=4'hF; then read 0x10.
   - Required: o_Busy high for 2 cycles per access; o_Done in cycle 3; read returns 0xDEADBEEF.
2. Byte lanes:
   - Stimulus: word 0x20 holds 0x11223344; write 0xAABBCCDD with BE=4'b0101.
   - Required: read of 0x20 returns 0x11BB33DD.
3. Faults:
   - Stimulus: read 0x102 (misaligned), then write 0x100 with Depth=64 (out of range).
   - Required: each gives o_Done=1, o_Addr_Error=1 after 2 busy cycles; read data 0; RAM unchanged.
4. WaitStates=0:
   - Stimulus: alternate write/read of 0x04 every cycle.
   - Required: o_Busy never asserted; o_Done every cycle; each read returns the value written in the preceding cycle.
5. Reset mid-access:
   - Stimulus: i_RESET pulse during the first busy cycle of a write of 0x5A5A5A5A to 0x08.
   - Required: outputs go to 0 immediately (async); state IDLE; no o_Done; RAM[0x08] keeps its old value.
6. Simultaneous read and write:
   - Stimulus: i_Mem_Read=i_Mem_Write=1 at 0x0C, data 0x12345678.
   - Required: treated as a write; o_Read_Data=0 at completion; a later read returns 0x12345678.
